// File: rtl/sap1_program_loader.sv
// SAP-1 program loader: streams bytes into the 16x8 RAM over valid/ready,
// verifies each word by readback, then releases the CPU clear.
module sap1_program_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LOAD_COUNT = 16
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  cpu_clr_n,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_WRITE,
        S_VERIFY,
        S_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_COUNT - 1);

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_err, w_err_nxt;
    logic [ADDR_WIDTH-1:0] r_err_addr, w_err_addr_nxt;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_err      <= w_err_nxt;
            r_err_addr <= w_err_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_err_nxt      = r_err;
        w_err_addr_nxt = r_err_addr;
        ready          = 1'b0;
        ram_we         = 1'b0;
        cpu_clr_n      = 1'b0;
        done           = 1'b0;

        case (r_state)
            S_IDLE: ;
            S_WAIT_BYTE: begin
                ready = 1'b1;
                if (data_valid) begin
                    w_data_nxt  = data_in;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_we      = 1'b1;
                w_state_nxt = S_VERIFY;
            end
            S_VERIFY: begin
                if ((ram_q != r_data) && !r_err) begin
                    w_err_nxt      = 1'b1;
                    w_err_addr_nxt = r_addr;
                end
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                    w_state_nxt = S_WAIT_BYTE;
                end
            end
            S_RUN: begin
                done      = 1'b1;
                // A failed image keeps the core held in clear.
                cpu_clr_n = !r_err;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // load_start wins in every state; a write already in WRITE still strobes.
        if (load_start) begin
            w_state_nxt    = S_WAIT_BYTE;
            w_addr_nxt     = '0;
            w_data_nxt     = r_data;
            w_err_nxt      = 1'b0;
            w_err_addr_nxt = '0;
        end
    end

    assign ram_addr = r_addr;
    assign ram_data = r_data;
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Directed self-checking bench for sap1_program_loader with a behavioural
// 16x8 RAM that can inject a bit-0 stuck-at-1 fault at addresses 5 and 12.
module tb_sap1_program_loader;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       load_start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_q;
    logic       cpu_clr_n;
    logic       done;
    logic       err;
    logic [3:0] err_addr;

    logic [7:0] mem [16];
    logic       fault_en = 1'b0;
    logic [7:0] img [16];
    logic [3:0] log_a [$];
    logic [7:0] log_d [$];
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    sap1_program_loader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .LOAD_COUNT(16)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .load_start(load_start),
        .data_in(data_in),
        .data_valid(data_valid),
        .ready(ready),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_we(ram_we),
        .ram_q(ram_q),
        .cpu_clr_n(cpu_clr_n),
        .done(done),
        .err(err),
        .err_addr(err_addr)
    );

    always #5 CLK = ~CLK;

    always_comb ram_q = mem[ram_addr] |
        ((fault_en && (ram_addr == 4'd5 || ram_addr == 4'd12)) ? 8'h01 : 8'h00);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
            log_a.push_back(ram_addr);
            log_d.push_back(ram_data);
        end
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    // Offers a byte and returns at the negedge after it was accepted (WRITE state).
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        data_in = b;
        data_valid = 1'b1;
        while (!ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: ready=%0b required 1", ready);
        end
        @(negedge CLK);
    endtask

    task automatic wait_done(output int cycles);
        int t;
        t = 0;
        while (!done && t < 20) begin
            @(negedge CLK);
            t++;
        end
        cycles = t;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: done=%0b required 1", done);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ready, ram_we, ram_addr, ram_data, cpu_clr_n, done, err, err_addr} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ready, ram_we, ram_addr, ram_data, cpu_clr_n, done, err, err_addr});
        end
        @(negedge CLK);
        CLR = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({cpu_clr_n, ready, ram_we, done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: clr_n/ready/we/done=%b required 0000", i,
                         {cpu_clr_n, ready, ram_we, done});
            end
        end
    endtask

    task automatic test_full_load();
        int base, cycles;
        int unsigned t0;
        logic [7:0] pat [16];
        pat = '{8'h0E, 8'h1F, 8'h2D, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        img = pat;
        base = log_a.size();
        pulse_start();
        t0 = cyc;
        for (int i = 0; i < 16; i++) send_byte(img[i]);
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== 4'd15 || cpu_clr_n !== 1'b0) begin
            n_fail++;
            $display("FAIL full_last_write: we=%0b addr=%0d clr_n=%0b required 1 15 0",
                     ram_we, ram_addr, cpu_clr_n);
        end
        data_valid = 1'b0;
        wait_done(cycles);
        n_checks++;
        if (cyc - t0 !== 48) begin
            n_fail++;
            $display("FAIL full_latency: got %0d cycles required 48", cyc - t0);
        end
        n_checks++;
        if ({done, cpu_clr_n, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL full_run: done/clr_n/err=%b required 110", {done, cpu_clr_n, err});
        end
        n_checks++;
        if (log_a.size() - base !== 16) begin
            n_fail++;
            $display("FAIL full_write_count: got %0d required 16", log_a.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (log_a[base+i] !== 4'(i) || log_d[base+i] !== img[i]) begin
                    n_fail++;
                    $display("FAIL full_write%0d: addr=%0d data=%h required %0d %h", i,
                             log_a[base+i], log_d[base+i], i, img[i]);
                end
            end
        end
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({done, cpu_clr_n, ready, ram_we} !== 4'b1100) begin
            n_fail++;
            $display("FAIL full_run_hold: done/clr_n/ready/we=%b required 1100",
                     {done, cpu_clr_n, ready, ram_we});
        end
    endtask

    task automatic test_back_pressure();
        int base, cycles;
        for (int i = 0; i < 16; i++) img[i] = 8'hA0 + 8'(i);
        base = log_a.size();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(img[i]);
        data_valid = 1'b0;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'd3) begin
                n_fail++;
                $display("FAIL bp_stall%0d: ready=%0b we=%0b addr=%0d required 1 0 3", i,
                         ready, ram_we, ram_addr);
            end
            @(negedge CLK);
        end
        for (int i = 3; i < 16; i++) send_byte(img[i]);
        data_valid = 1'b0;
        wait_done(cycles);
        n_checks++;
        if ({done, cpu_clr_n, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL bp_run: done/clr_n/err=%b required 110", {done, cpu_clr_n, err});
        end
        n_checks++;
        if (log_a.size() - base !== 16) begin
            n_fail++;
            $display("FAIL bp_write_count: got %0d required 16", log_a.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (log_a[base+i] !== 4'(i) || log_d[base+i] !== img[i]) begin
                    n_fail++;
                    $display("FAIL bp_write%0d: addr=%0d data=%h required %0d %h", i,
                             log_a[base+i], log_d[base+i], i, img[i]);
                end
            end
        end
    endtask

    task automatic test_verify_failure();
        int cycles;
        for (int i = 0; i < 16; i++) img[i] = 8'h30 + 8'(i);
        img[5] = 8'h10;
        fault_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(img[i]);
        data_valid = 1'b0;
        wait_done(cycles);
        n_checks++;
        if (err !== 1'b1 || err_addr !== 4'd5) begin
            n_fail++;
            $display("FAIL vf_err: err=%0b err_addr=%0d required 1 5", err, err_addr);
        end
        n_checks++;
        if (done !== 1'b1 || cpu_clr_n !== 1'b0) begin
            n_fail++;
            $display("FAIL vf_hold: done=%0b clr_n=%0b required 1 0", done, cpu_clr_n);
        end
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({done, cpu_clr_n, err, err_addr} !== 7'b1_0_1_0101) begin
            n_fail++;
            $display("FAIL vf_sticky: done=%0b clr_n=%0b err=%0b err_addr=%0d required 1 0 1 5",
                     done, cpu_clr_n, err, err_addr);
        end
        fault_en = 1'b0;
        pulse_start();
        n_checks++;
        if ({err, err_addr, done, cpu_clr_n, ready} !== 8'b0_0000_0_0_1) begin
            n_fail++;
            $display("FAIL vf_restart: err=%0b err_addr=%0d done=%0b clr_n=%0b ready=%0b required 0 0 0 0 1",
                     err, err_addr, done, cpu_clr_n, ready);
        end
        for (int i = 0; i < 16; i++) send_byte(img[i]);
        data_valid = 1'b0;
        wait_done(cycles);
        n_checks++;
        if ({done, cpu_clr_n, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL vf_reload: done/clr_n/err=%b required 110", {done, cpu_clr_n, err});
        end
    endtask

    task automatic test_restart();
        int base, cycles;
        for (int i = 0; i < 16; i++) img[i] = 8'h40 + 8'(i);
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(img[i]);
        data_valid = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (ready !== 1'b1 || ram_addr !== 4'd7) begin
            n_fail++;
            $display("FAIL rs_at7: ready=%0b addr=%0d required 1 7", ready, ram_addr);
        end
        base = log_a.size();
        load_start = 1'b1;
        data_in = 8'hEE;
        data_valid = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'd0 || log_a.size() != base) begin
            n_fail++;
            $display("FAIL rs_priority: ready=%0b we=%0b addr=%0d writes=%0d required 1 0 0 0",
                     ready, ram_we, ram_addr, log_a.size() - base);
        end
        for (int i = 0; i < 16; i++) send_byte(img[i]);
        data_valid = 1'b0;
        wait_done(cycles);
        n_checks++;
        if (log_a.size() - base !== 16) begin
            n_fail++;
            $display("FAIL rs_write_count: got %0d required 16", log_a.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (log_a[base+i] !== 4'(i) || log_d[base+i] !== img[i]) begin
                    n_fail++;
                    $display("FAIL rs_write%0d: addr=%0d data=%h required %0d %h", i,
                             log_a[base+i], log_d[base+i], i, img[i]);
                end
            end
        end
        n_checks++;
        if ({done, cpu_clr_n, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL rs_run: done/clr_n/err=%b required 110", {done, cpu_clr_n, err});
        end
    endtask

    task automatic test_reset_mid_write();
        int base;
        for (int i = 0; i < 16; i++) img[i] = 8'h60 + 8'(i);
        base = log_a.size();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(img[i]);
        data_valid = 1'b0;
        n_checks++;
        if (ram_we !== 1'b1 || ram_addr !== 4'd9) begin
            n_fail++;
            $display("FAIL rw_in_write: we=%0b addr=%0d required 1 9", ram_we, ram_addr);
        end
        #1 CLR = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || cpu_clr_n !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_async: we=%0b clr_n=%0b ready=%0b required 0 0 0",
                     ram_we, cpu_clr_n, ready);
        end
        @(negedge CLK);
        n_checks++;
        if (log_a.size() - base !== 9 || mem[8] !== 8'h68) begin
            n_fail++;
            $display("FAIL rw_partial: writes=%0d mem8=%h required 9 68",
                     log_a.size() - base, mem[8]);
        end
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({done, ready, cpu_clr_n, ram_we, ram_addr} !== 8'h00) begin
            n_fail++;
            $display("FAIL rw_idle: done/ready/clr_n/we/addr=%b required 0",
                     {done, ready, cpu_clr_n, ram_we, ram_addr});
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_back_pressure();
        test_verify_failure();
        test_restart();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_program_loader.md
Name: sap1_program_loader

Overview:
- Writes a program image into the SAP-1 16x8 RAM before execution. It is the writer counterpart to the controller/sequencer, which only reads RAM via MAR/CE.
- Accepts bytes over a valid/ready handshake, writes each one to consecutive RAM addresses, reads each back to verify it, then releases the CPU from reset.
- Sits between the external program source (switch panel or serial front end) and the RAM write port. It also drives the CPU-side active-low clear.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 4, RAM address width
LOAD_COUNT, 16, number of words loaded per image, 1..2**ADDR_WIDTH

Ports:
CLK  input  1  system clock; all state updates on rising edge
CLR  input  1  asynchronous active-low reset
load_start  input  1  one-cycle pulse that begins or restarts a load
data_in  input  DATA_WIDTH  program byte from source
data_valid  input  1  data_in valid
ready  output  1  loader accepts data_in this cycle
ram_addr  output  ADDR_WIDTH  RAM address (write and readback)
ram_data  output  DATA_WIDTH  RAM write data
ram_we  output  1  RAM write enable, active-high, one cycle per word
ram_q  input  DATA_WIDTH  RAM combinational read data at ram_addr
cpu_clr_n  output  1  active-low clear to the SAP-1 core (sequencer CLR)
done  output  1  image loaded; CPU released
err  output  1  sticky readback-mismatch flag
err_addr  output  ADDR_WIDTH  address of first mismatch

Behaviour:
- Reset (CLR=0, asynchronous) forces these values:
  - state=IDLE, addr=0, data_reg=0
  - ready=0, ram_we=0, ram_addr=0, ram_data=0
  - cpu_clr_n=0, done=0, err=0, err_addr=0
- States: IDLE, WAIT_BYTE, WRITE, VERIFY, RUN.
- IDLE:
  - cpu_clr_n=0; the CPU stays halted after reset until an image is loaded.
  - load_start=1 -> WAIT_BYTE; clear addr, err and err_addr.
- WAIT_BYTE:
  - ready=1, ram_addr=addr.
  - On data_valid&&ready: capture data_in into data_reg, go to WRITE.
  - No valid: hold indefinitely.
- WRITE:
  - ram_we=1, ram_addr=addr, ram_data=data_reg for exactly one cycle; ready=0.
  - Next state VERIFY.
- VERIFY:
  - ram_we=0, ram_addr=addr.
  - If ram_q!=data_reg and err=0: set err=1, err_addr=addr. err is sticky; err_addr keeps the first mismatch.
  - If addr==LOAD_COUNT-1: go to RUN.
  - Otherwise addr=addr+1, go to WAIT_BYTE.
- RUN:
  - cpu_clr_n=1, done=1, ready=0, ram_we=0. cpu_clr_n rises on the cycle RUN is entered.
  - If err=1 at entry: stay in RUN with cpu_clr_n held 0 and done=1, so a failed image never executes.
  - load_start=1 -> WAIT_BYTE in the next cycle: cpu_clr_n=0, done=0, addr=0, err and err_addr cleared.
- Throughput: 3 cycles per word minimum (accept, write, verify). For LOAD_COUNT=16 with data_valid held high, RUN is reached 48 cycles after the first accept.
- load_start in WAIT_BYTE, WRITE or VERIFY restarts the load: addr=0, err cleared, go to WAIT_BYTE.
  - An in-progress write completes only if already in WRITE that cycle; ram_we never exceeds one cycle.
- load_start together with data_valid in WAIT_BYTE: restart takes priority; the byte is not accepted.
- Address wrap: addr never exceeds LOAD_COUNT-1; it never wraps within a load.
- Asynchronous reset mid-operation:
  - ram_we drops immediately and cpu_clr_n goes to 0 immediately.
  - The partially written image is left in RAM.
- ready depends only on state (registered), never combinationally on data_valid.

Test Plan:
- Reset then idle: release CLR, no load_start for 20 cycles -> cpu_clr_n=0, ready=0, ram_we=0, done=0 throughout.
- Full load: pulse load_start, stream 0x0E,0x1F,0x2D,0xE0,0xF0, then 11 words of 0x00, with data_valid held 1 and a model RAM.
  - ram_we pulses once per word at addresses 0..15 with the matching data.
  - done=1 and cpu_clr_n=1 at cycle 48 after the first accept; err=0.
- Back-pressure: deassert data_valid for 5 cycles before word 3 -> ready stays 1, no ram_we, addr holds 3, and the load then completes correctly.
- Verify failure: model RAM forces bit 0 stuck-at-1 at address 5, image byte 0x10 -> err=1, err_addr=5, done=1, cpu_clr_n stays 0.
  - Follow with load_start and a fault-free RAM -> err clears and cpu_clr_n=1 at completion.
- Restart mid-load: load_start asserted with data_valid in WAIT_BYTE at addr 7 -> byte not accepted, next write goes to addr 0, and exactly 16 further writes occur.
- Reset mid-write: drop CLR during the WRITE state for address 9 -> ram_we=0 and cpu_clr_n=0 asynchronously; after release the state is IDLE and done=0.
